ksa_frame_sequencer: RTL
========================

# ksa_frame_sequencer

Sequences the fault-correcting 16-bit Kogge-Stone adder between the UART receiver and the UART transmitter. It assembles a 5-byte operand frame from the received byte stream and drives the adder operands. It holds correction enabled for a fixed settle window, then captures the corrected and uncorrected results. Finally it streams a 6-byte result frame to the transmitter through its xmit/done handshake. It runs entirely in the baud clock domain.

## Interface
- SETTLE_CYCLES, 5: cycles correction_enable is held high before capture (1..255).
- RX_TIMEOUT, 1023: idle cycles allowed between bytes of one frame before the partial frame is discarded (1..65535).

Ports:
- baud_clock  in  1  clock; all logic is on posedge.
- reset  in  1  asynchronous, active-low.
- rx_byte  in  8  received byte.
- rx_valid  in  1  one-cycle strobe for rx_byte; already synchronized.
- add_a  out  16  adder operand a.
- add_b  out  16  adder operand b.
- add_cin  out  1  adder carry-in.
- correction_enable  out  1  adder correction enable.
- corrected_sum  in  16  adder result.
- uncorrected_sum  in  16  adder raw result.
- cout  in  1  adder carry-out.
- tx_start  out  1  request to the transmitter (xmitH).
- tx_data  out  8  byte to transmit.
- tx_done  in  1  transmitter idle (high when idle, low while shifting).
- busy  out  1  high in every state except IDLE.
- fault_flag  out  1  corrected_sum != uncorrected_sum at the last capture.
- frame_count  out  8  completed frames; wraps 255 to 0.
- err_timeout  out  1  one-cycle pulse when a partial frame is dropped.
- rx_overrun  out  1  one-cycle pulse when rx_valid arrives outside IDLE/COLLECT.

## Operation
- RX frame byte order:
  - byte0 = a[7:0]
  - byte1 = a[15:8]
  - byte2 = b[7:0]
  - byte3 = b[15:8]
  - byte4 = cin in bit 0; bits 7:1 are ignored.
- TX frame byte order:
  - byte0 = 8'h00
  - byte1 = corrected[15:8]
  - byte2 = corrected[7:0]
  - byte3 = {6'b0, fault, cout}
  - byte4 = uncorrected[15:8]
  - byte5 = uncorrected[7:0]
- States:
  - IDLE: on rx_valid, store byte0, set rx_ptr=1, go to COLLECT.
  - COLLECT: on each rx_valid, store the byte at rx_ptr and increment rx_ptr. When byte4 is stored, go to SETTLE. If the gap counter reaches RX_TIMEOUT, clear rx_ptr, pulse err_timeout and go to IDLE.
  - SETTLE: correction_enable=1 for exactly SETTLE_CYCLES cycles, then go to CAPTURE.
  - CAPTURE: one cycle. Register corrected, uncorrected and cout, update fault_flag, clear tx_ptr, go to SEND.
  - SEND: tx_start=1. Stay until tx_done is low, then go to WAIT_DONE.
  - WAIT_DONE: wait for tx_done high. If tx_ptr==5, increment frame_count and go to IDLE. Otherwise go to NEXT.
  - NEXT: increment tx_ptr, go to SEND. This gives one cycle for tx_data to settle before tx_start.
- Operand registers change only when a byte is stored. add_a, add_b and add_cin stay stable from SETTLE through the end of the TX frame.
- tx_data is a combinational mux of tx_ptr over the captured registers.
- Simultaneous events:
  - rx_valid on the same cycle the timeout would fire: the byte is accepted and the gap counter resets.
  - rx_valid in SETTLE through NEXT: the byte is dropped, rx_overrun pulses, and the sequence is unaffected.
- tx_done stuck high: the block stays in SEND indefinitely with no timeout.
- Reset asserted mid-operation: all state clears immediately. The transmitter shares the same reset.

## Timing
- Reset values:
  - all outputs 0.
  - tx_data = 8'h00 (tx_ptr=0).
  - state IDLE.
- Timing from the cycle byte4 is accepted:
  - correction_enable rises the next cycle.
  - Capture happens SETTLE_CYCLES+1 cycles after byte4 is accepted.
  - tx_start first asserts one cycle after capture.
- fault_flag, captured results and frame_count hold their values until the next CAPTURE or wrap.
- err_timeout and rx_overrun are registered pulses exactly one cycle wide.
- Gap counter: 16 bits, saturating, cleared on every rx_valid.

## Structure
- Shared package ksa_seq_pkg holds:
  - the state enum
  - the TX header constant 8'h00
  - the RX/TX frame length constants (5, 6)
  - the byte-index constants
- One sub-module, ksa_frame_rx: byte assembler with gap counter and timeout. It outputs a_reg, b_reg, cin_reg, a frame_ready pulse and the timeout pulse.
- The top-level FSM, capture registers and TX mux stay in ksa_frame_sequencer.

## Test plan
- Basic add:
  - Stimulus: RX 34 12 F1 0F 01 (a=0x1234, b=0x0FF1, cin=1).
  - Required: correction_enable high for 5 cycles, then TX 00 22 26 00 22 26; fault_flag=0; frame_count=1.
- Carry out:
  - Stimulus: RX FF FF 01 00 00.
  - Required: TX 00 00 00 01 00 00.
- Fault detection:
  - Stimulus: the adder model returns uncorrected 0x2A26 against corrected 0x2226.
  - Required: byte3=0x02 (cout=0); fault_flag=1 held until the next capture.
- Timeout:
  - Stimulus: 3 bytes, then RX_TIMEOUT idle cycles.
  - Required: single err_timeout pulse; the next 5 bytes form a fresh frame with the correct sum.
- Overrun:
  - Stimulus: rx_valid during SEND.
  - Required: one rx_overrun pulse; TX bytes and operands unchanged.
- Reset mid-frame:
  - Stimulus: reset asserted during byte 2 of TX, with frame_count at 255.
  - Required: all outputs go to reset values asynchronously; after release, a full frame brings frame_count to 1.
- frame_count wrap:
  - Stimulus: 256 frames with no reset.
  - Required: frame_count wraps to 0.

Source files
------------

// File: rtl/ksa_seq_pkg.sv
// Shared types and frame layout constants for the KSA frame sequencer.
// Byte indices match the wire order of the RX operand frame and the TX result frame.
package ksa_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_SETTLE,
        S_CAPTURE,
        S_SEND,
        S_WAIT_DONE,
        S_NEXT
    } state_t;

    localparam logic [7:0] TX_HDR = 8'h00;

    localparam int RX_LEN = 5;
    localparam int TX_LEN = 6;
    localparam logic [2:0] RX_LAST = 3'(RX_LEN - 1);
    localparam logic [2:0] TX_LAST = 3'(TX_LEN - 1);

    localparam logic [2:0] RX_A_LO = 3'd0;
    localparam logic [2:0] RX_A_HI = 3'd1;
    localparam logic [2:0] RX_B_LO = 3'd2;
    localparam logic [2:0] RX_B_HI = 3'd3;
    localparam logic [2:0] RX_CIN  = 3'd4;

    localparam logic [2:0] TX_IDX_HDR     = 3'd0;
    localparam logic [2:0] TX_IDX_CORR_HI = 3'd1;
    localparam logic [2:0] TX_IDX_CORR_LO = 3'd2;
    localparam logic [2:0] TX_IDX_FLAGS   = 3'd3;
    localparam logic [2:0] TX_IDX_UNC_HI  = 3'd4;
    localparam logic [2:0] TX_IDX_UNC_LO  = 3'd5;

endpackage

// File: rtl/ksa_frame_rx.sv
// Operand frame assembler: stores accepted bytes into a/b/cin, flags the last byte,
// and drops a partial frame after RX_TIMEOUT idle cycles between bytes.
module ksa_frame_rx
    import ksa_seq_pkg::*;
#(
    parameter int RX_TIMEOUT = 1023
) (
    input  logic        baud_clock,
    input  logic        reset,
    input  logic [7:0]  rx_byte,
    input  logic        rx_valid,
    input  logic        accept,
    output logic [15:0] a_reg,
    output logic [15:0] b_reg,
    output logic        cin_reg,
    output logic        frame_ready,
    output logic        timeout_hit
);

    localparam logic [15:0] GAP_LAST = 16'(RX_TIMEOUT - 1);

    logic [2:0]  rx_ptr;
    logic [15:0] gap_cnt;
    logic        store;

    assign store       = accept && rx_valid;
    assign frame_ready = store && (rx_ptr == RX_LAST);
    // A byte arriving on the would-be timeout cycle wins: it is stored and the gap restarts.
    assign timeout_hit = (rx_ptr != 3'd0) && !rx_valid && (gap_cnt == GAP_LAST);

    always_ff @(posedge baud_clock or negedge reset) begin
        if (!reset) begin
            rx_ptr  <= 3'd0;
            gap_cnt <= 16'd0;
            a_reg   <= 16'd0;
            b_reg   <= 16'd0;
            cin_reg <= 1'b0;
        end else begin
            if (rx_valid) begin
                gap_cnt <= 16'd0;
            end else if (gap_cnt != 16'hFFFF) begin
                gap_cnt <= gap_cnt + 16'd1;
            end

            if (store) begin
                case (rx_ptr)
                    RX_A_LO: a_reg[7:0]  <= rx_byte;
                    RX_A_HI: a_reg[15:8] <= rx_byte;
                    RX_B_LO: b_reg[7:0]  <= rx_byte;
                    RX_B_HI: b_reg[15:8] <= rx_byte;
                    RX_CIN:  cin_reg     <= rx_byte[0];
                    default: ;
                endcase
                rx_ptr <= frame_ready ? 3'd0 : rx_ptr + 3'd1;
            end else if (timeout_hit) begin
                rx_ptr <= 3'd0;
            end
        end
    end

endmodule

// File: rtl/ksa_frame_sequencer.sv
// Drives the KSA adder from a 5-byte RX frame, holds correction for a settle window,
// captures both results and streams a 6-byte result frame over the xmit/done handshake.
module ksa_frame_sequencer
    import ksa_seq_pkg::*;
#(
    parameter int SETTLE_CYCLES = 5,
    parameter int RX_TIMEOUT    = 1023
) (
    input  logic        baud_clock,
    input  logic        reset,
    input  logic [7:0]  rx_byte,
    input  logic        rx_valid,
    output logic [15:0] add_a,
    output logic [15:0] add_b,
    output logic        add_cin,
    output logic        correction_enable,
    input  logic [15:0] corrected_sum,
    input  logic [15:0] uncorrected_sum,
    input  logic        cout,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    input  logic        tx_done,
    output logic        busy,
    output logic        fault_flag,
    output logic [7:0]  frame_count,
    output logic        err_timeout,
    output logic        rx_overrun
);

    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

    state_t      state;
    state_t      state_nxt;
    logic [7:0]  settle_cnt;
    logic [2:0]  tx_ptr;
    logic [15:0] corr_q;
    logic [15:0] unc_q;
    logic        cout_q;
    logic        accept;
    logic        frame_ready;
    logic        timeout_hit;

    assign accept = (state == S_IDLE) || (state == S_COLLECT);

    ksa_frame_rx #(
        .RX_TIMEOUT(RX_TIMEOUT)
    ) u_rx (
        .baud_clock  (baud_clock),
        .reset       (reset),
        .rx_byte     (rx_byte),
        .rx_valid    (rx_valid),
        .accept      (accept),
        .a_reg       (add_a),
        .b_reg       (add_b),
        .cin_reg     (add_cin),
        .frame_ready (frame_ready),
        .timeout_hit (timeout_hit)
    );

    always_ff @(posedge baud_clock or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:      if (rx_valid) state_nxt = S_COLLECT;
            S_COLLECT: begin
                if (frame_ready) begin
                    state_nxt = S_SETTLE;
                end else if (timeout_hit) begin
                    state_nxt = S_IDLE;
                end
            end
            S_SETTLE:    if (settle_cnt == SETTLE_LAST) state_nxt = S_CAPTURE;
            S_CAPTURE:   state_nxt = S_SEND;
            S_SEND:      if (!tx_done) state_nxt = S_WAIT_DONE;
            S_WAIT_DONE: if (tx_done) state_nxt = (tx_ptr == TX_LAST) ? S_IDLE : S_NEXT;
            S_NEXT:      state_nxt = S_SEND;
            default:     state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy              = (state != S_IDLE);
        correction_enable = (state == S_SETTLE);
        tx_start          = (state == S_SEND);
    end

    always_ff @(posedge baud_clock or negedge reset) begin
        if (!reset) begin
            settle_cnt  <= 8'd0;
            tx_ptr      <= 3'd0;
            corr_q      <= 16'd0;
            unc_q       <= 16'd0;
            cout_q      <= 1'b0;
            fault_flag  <= 1'b0;
            frame_count <= 8'd0;
            err_timeout <= 1'b0;
            rx_overrun  <= 1'b0;
        end else begin
            settle_cnt  <= (state == S_SETTLE) ? settle_cnt + 8'd1 : 8'd0;
            err_timeout <= timeout_hit;
            rx_overrun  <= rx_valid && !accept;
            if (state == S_CAPTURE) begin
                corr_q     <= corrected_sum;
                unc_q      <= uncorrected_sum;
                cout_q     <= cout;
                fault_flag <= (corrected_sum != uncorrected_sum);
                tx_ptr     <= 3'd0;
            end
            if (state == S_NEXT) begin
                tx_ptr <= tx_ptr + 3'd1;
            end
            if ((state == S_WAIT_DONE) && tx_done && (tx_ptr == TX_LAST)) begin
                frame_count <= frame_count + 8'd1;
            end
        end
    end

    // tx_ptr moves one cycle ahead of tx_start (NEXT state), so this mux is settled at the request.
    always_comb begin
        tx_data = TX_HDR;
        case (tx_ptr)
            TX_IDX_HDR:     tx_data = TX_HDR;
            TX_IDX_CORR_HI: tx_data = corr_q[15:8];
            TX_IDX_CORR_LO: tx_data = corr_q[7:0];
            TX_IDX_FLAGS:   tx_data = {6'b0, fault_flag, cout_q};
            TX_IDX_UNC_HI:  tx_data = unc_q[15:8];
            TX_IDX_UNC_LO:  tx_data = unc_q[7:0];
            default:        tx_data = TX_HDR;
        endcase
    end

endmodule
